// File: rtl/int_pkg.sv
// int_pkg
// Shared types and constants for the interrupt/reset sequencer.
//   int_state_t : sequencer FSM state
//   VEC_*       : vector addresses presented to the address generator
//   OP_BRK      : opcode the control PLA treats as reset/BRK entry
package int_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } int_state_t;

  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  localparam logic [7:0]  OP_BRK    = 8'h00;

endpackage

// File: rtl/int_sequencer_sync_chain.sv
// sync_chain
// Shift-register synchroniser for an asynchronous active-low pin.
// All stages preset to 1 (pin inactive) while reset is high.
// Ports:
//   ph1   - clock
//   reset - synchronous, active-high
//   d     - raw pin
//   q     - synchronised pin (output of the last stage)
module sync_chain
  import int_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic ph1,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  if (DEPTH == 1) begin : g_one
    always_comb chain_d = d;
  end else begin : g_multi
    always_comb chain_d = {chain_q[DEPTH-2:0], d};
  end

  always_ff @(posedge ph1) begin
    if (reset) chain_q <= '1;
    else       chain_q <= chain_d;
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/int_sequencer.sv
// int_sequencer
// Interrupt and reset sequencer in front of the control FSM opcode input.
// Arbitrates reset > NMI > IRQ > software BRK at each opcode fetch and
// substitutes OP_BRK for hardware entries.
//
// Build option: INT_SYNC_EN
//   defined   - nmi_n/irq_n go through SYNC_STAGES synchroniser flops.
//   undefined - pins pass through one register (synchronous stimulus only);
//               SYNC_STAGES is ignored.
//
// Ports:
//   ph1, reset         - clock, synchronous active-high reset
//   nmi_n, irq_n       - interrupt pins (NMI falling edge, IRQ low level)
//   data_in            - byte from memory bus
//   p                  - processor status, p[2] = I flag
//   fetch              - opcode-fetch cycle marker
//   opcode_out         - byte to control FSM (combinational)
//   vector             - vector address for the entry sequence
//   b_flag             - B bit for pushed status
//   int_active         - high from the injecting fetch to the next fetch
//   cpu_reset          - stretched reset to control/datapath
//
// state   | meaning
// IDLE    | no entry sequence in progress
// SERVICE | entry injected, waiting for the next fetch
module int_sequencer
  import int_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 4
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic [7:0]  data_in,
  input  logic [7:0]  p,
  input  logic        fetch,
  output logic [7:0]  opcode_out,
  output logic [15:0] vector,
  output logic        b_flag,
  output logic        int_active,
  output logic        cpu_reset
);

`ifdef INT_SYNC_EN
  localparam int DEPTH = SYNC_STAGES;
`else
  // Single sampling register; SYNC_STAGES deliberately has no effect here.
  localparam int DEPTH = (SYNC_STAGES > 0) ? 1 : 1;
`endif

  localparam logic [3:0] HOLD_INIT = RST_HOLD[3:0];

  logic nmi_sync, irq_sync;

  sync_chain #(.DEPTH(DEPTH)) u_nmi_sync (
    .ph1(ph1), .reset(reset), .d(nmi_n), .q(nmi_sync)
  );

  sync_chain #(.DEPTH(DEPTH)) u_irq_sync (
    .ph1(ph1), .reset(reset), .d(irq_n), .q(irq_sync)
  );

  int_state_t  state_q, state_d;
  logic        rst_pend_q, rst_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_prev_q;
  logic [15:0] vector_q, vector_d;
  logic        b_flag_q, b_flag_d;
  logic        int_active_q, int_active_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;

  logic fetch_ok, nmi_fall, irq_req, hw_inj, take_nmi;

  logic unused_p;
  assign unused_p = ^{p[7:3], p[1:0]};

  always_comb begin
    fetch_ok     = fetch & ~cpu_reset_q;
    nmi_fall     = nmi_prev_q & ~nmi_sync;
    irq_req      = ~irq_sync & ~p[2];

    hold_cnt_d   = (hold_cnt_q != 4'd0) ? hold_cnt_q - 4'd1 : 4'd0;
    cpu_reset_d  = (hold_cnt_d != 4'd0);

    state_d      = state_q;
    rst_pend_d   = rst_pend_q;
    vector_d     = vector_q;
    b_flag_d     = b_flag_q;
    int_active_d = int_active_q;
    hw_inj       = 1'b0;
    take_nmi     = 1'b0;

    if (fetch_ok) begin
      // Any fetch ends a service window; arbitration may reopen it at once.
      state_d      = IDLE;
      int_active_d = 1'b0;
      if (rst_pend_q) begin
        vector_d   = VEC_RESET;
        rst_pend_d = 1'b0;
        hw_inj     = 1'b1;
      end else if (nmi_pend_q) begin
        vector_d   = VEC_NMI;
        take_nmi   = 1'b1;
        hw_inj     = 1'b1;
      end else if (irq_req) begin
        vector_d   = VEC_IRQ;
        hw_inj     = 1'b1;
      end else if (data_in == OP_BRK) begin
        vector_d     = VEC_IRQ;
        b_flag_d     = 1'b1;
        state_d      = SERVICE;
        int_active_d = 1'b1;
      end
      if (hw_inj) begin
        b_flag_d     = 1'b0;
        state_d      = SERVICE;
        int_active_d = 1'b1;
      end
    end

    // A new edge wins over the clear so it is never lost.
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~take_nmi);

    opcode_out = hw_inj ? OP_BRK : data_in;
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q      <= IDLE;
      rst_pend_q   <= 1'b1;
      nmi_pend_q   <= 1'b0;
      nmi_prev_q   <= 1'b1;
      vector_q     <= VEC_RESET;
      b_flag_q     <= 1'b0;
      int_active_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
      hold_cnt_q   <= HOLD_INIT;
    end else begin
      state_q      <= state_d;
      rst_pend_q   <= rst_pend_d;
      nmi_pend_q   <= nmi_pend_d;
      nmi_prev_q   <= nmi_sync;
      vector_q     <= vector_d;
      b_flag_q     <= b_flag_d;
      int_active_q <= int_active_d;
      cpu_reset_q  <= cpu_reset_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign vector     = vector_q;
  assign b_flag     = b_flag_q;
  assign int_active = int_active_q;
  assign cpu_reset  = cpu_reset_q;

endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer
// Self-checking bench for int_sequencer: reset hold, reset/NMI/IRQ/BRK
// entries, priority, back-to-back service and NMI edge retention.
module tb_int_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int RST_HOLD    = 4;
`ifdef INT_SYNC_EN
  localparam int LAT = SYNC_STAGES + 1;
`else
  localparam int LAT = 2;
`endif

  logic        ph1;
  logic        reset;
  logic        nmi_n;
  logic        irq_n;
  logic [7:0]  data_in;
  logic [7:0]  p;
  logic        fetch;
  logic [7:0]  opcode_out;
  logic [15:0] vector;
  logic        b_flag;
  logic        int_active;
  logic        cpu_reset;

  int_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_HOLD   (RST_HOLD)
  ) dut (
    .ph1       (ph1),
    .reset     (reset),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .data_in   (data_in),
    .p         (p),
    .fetch     (fetch),
    .opcode_out(opcode_out),
    .vector    (vector),
    .b_flag    (b_flag),
    .int_active(int_active),
    .cpu_reset (cpu_reset)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] vec;
    logic        b;
    logic        act;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge ph1);
    #1;
  endtask

  // One fetch cycle: expectation queued with the stimulus, popped when the
  // DUT answers (opcode mid-cycle, registered outputs after the edge).
  task automatic do_fetch(input string tag, input logic [7:0] d,
                          input logic [7:0] pp, input logic [7:0] e_op,
                          input logic [15:0] e_vec, input logic e_b,
                          input logic e_act);
    exp_t e;
    sb.push_back({e_op, e_vec, e_b, e_act});
    data_in = d;
    p       = pp;
    fetch   = 1'b1;
    #2;
    e = sb.pop_front();
    check_val({tag, ".op"}, {8'h00, opcode_out}, {8'h00, e.op});
    tick;
    fetch = 1'b0;
    check_val({tag, ".vec"}, vector, e.vec);
    check_val({tag, ".b"},   {15'd0, b_flag},     {15'd0, e.b});
    check_val({tag, ".act"}, {15'd0, int_active}, {15'd0, e.act});
  endtask

  initial begin
    reset   = 1'b1;
    nmi_n   = 1'b1;
    irq_n   = 1'b1;
    data_in = 8'h00;
    p       = 8'h04;
    fetch   = 1'b0;

    // Reset values and fetch ignored during reset hold
    tick;
    check_val("rst.vec",  vector, 16'hFFFC);
    check_val("rst.b",    {15'd0, b_flag},     16'd0);
    check_val("rst.act",  {15'd0, int_active}, 16'd0);
    check_val("rst.cpu",  {15'd0, cpu_reset},  16'd1);
    data_in = 8'hA9;
    fetch   = 1'b1;
    #1;
    check_val("rst.op_pass", {8'h00, opcode_out}, 16'h00A9);
    reset = 1'b0;
    for (int i = 1; i <= RST_HOLD; i++) begin
      tick;
      if (i == RST_HOLD) fetch = 1'b0;
      check_val($sformatf("hold%0d.cpu", i), {15'd0, cpu_reset},
                (i < RST_HOLD) ? 16'd1 : 16'd0);
      check_val($sformatf("hold%0d.act", i), {15'd0, int_active}, 16'd0);
      if (i < RST_HOLD)
        check_val($sformatf("hold%0d.op", i), {8'h00, opcode_out}, 16'h00A9);
    end

    do_fetch("rst_entry", 8'hA9, 8'h04, 8'h00, 16'hFFFC, 1'b0, 1'b1);
    do_fetch("post_rst",  8'h69, 8'h04, 8'h69, 16'hFFFC, 1'b0, 1'b0);

    // NMI latency boundary, service, release
    nmi_n = 1'b0;
    repeat (LAT - 1) tick;
    do_fetch("nmi_early", 8'h69, 8'h04, 8'h69, 16'hFFFC, 1'b0, 1'b0);
    do_fetch("nmi_svc",   8'h69, 8'h04, 8'h00, 16'hFFFA, 1'b0, 1'b1);
    do_fetch("nmi_done",  8'h69, 8'h04, 8'h69, 16'hFFFA, 1'b0, 1'b0);
    nmi_n = 1'b1;
    repeat (LAT + 1) tick;

    // IRQ masked, unmasked, and dropped when released before fetch
    irq_n = 1'b0;
    repeat (LAT) tick;
    do_fetch("irq_masked", 8'hEA, 8'h04, 8'hEA, 16'hFFFA, 1'b0, 1'b0);
    do_fetch("irq_svc",    8'hEA, 8'h00, 8'h00, 16'hFFFE, 1'b0, 1'b1);
    irq_n = 1'b1;
    repeat (LAT) tick;
    do_fetch("irq_drop",   8'hEA, 8'h00, 8'hEA, 16'hFFFE, 1'b0, 1'b0);

    // NMI beats IRQ, then IRQ back-to-back
    irq_n = 1'b0;
    nmi_n = 1'b0;
    repeat (LAT) tick;
    do_fetch("both_nmi",  8'hEA, 8'h00, 8'h00, 16'hFFFA, 1'b0, 1'b1);
    do_fetch("both_irq",  8'hEA, 8'h00, 8'h00, 16'hFFFE, 1'b0, 1'b1);
    irq_n = 1'b1;
    nmi_n = 1'b1;
    repeat (LAT + 1) tick;
    do_fetch("both_done", 8'hEA, 8'h00, 8'hEA, 16'hFFFE, 1'b0, 1'b0);

    // Software BRK
    do_fetch("brk",      8'h00, 8'h04, 8'h00, 16'hFFFE, 1'b1, 1'b1);
    do_fetch("brk_done", 8'h20, 8'h04, 8'h20, 16'hFFFE, 1'b1, 1'b0);

    // Second NMI edge lands in the cycle the first is serviced
    nmi_n = 1'b0;
    repeat (LAT) tick;
    nmi_n = 1'b1;
    repeat (LAT + 1) tick;
    nmi_n = 1'b0;
    repeat (LAT - 1) tick;
    do_fetch("nmi2_a", 8'hEA, 8'h04, 8'h00, 16'hFFFA, 1'b0, 1'b1);
    nmi_n = 1'b1;
    do_fetch("nmi2_b", 8'hEA, 8'h04, 8'h00, 16'hFFFA, 1'b0, 1'b1);
    do_fetch("nmi2_c", 8'hEA, 8'h04, 8'hEA, 16'hFFFA, 1'b0, 1'b0);

    // Reset mid-service with an NMI pending: all discarded
    do_fetch("brk2", 8'h00, 8'h04, 8'h00, 16'hFFFE, 1'b1, 1'b1);
    nmi_n = 1'b0;
    repeat (LAT) tick;
    nmi_n = 1'b1;
    reset = 1'b1;
    tick;
    check_val("rst2.vec", vector, 16'hFFFC);
    check_val("rst2.b",   {15'd0, b_flag},     16'd0);
    check_val("rst2.act", {15'd0, int_active}, 16'd0);
    check_val("rst2.cpu", {15'd0, cpu_reset},  16'd1);
    reset = 1'b0;
    repeat (RST_HOLD) tick;
    check_val("rst2.cpu_low", {15'd0, cpu_reset}, 16'd0);
    do_fetch("rst2_entry", 8'hA9, 8'h04, 8'h00, 16'hFFFC, 1'b0, 1'b1);
    do_fetch("rst2_nonmi", 8'hA9, 8'h04, 8'hA9, 16'hFFFC, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
